moa_rr_sched: RTL

- Round-robin scheduler that shares one 8-operand, 2-stage pipelined multi-operand adder (8×8-bit in, 11-bit registered sum out) among NREQ requesters.
- Each requester sends a burst of operand beats, 8 operands per beat, ending with a last flag.
- The block grants one requester for a whole burst and drives its beats into the adder.
- It tracks in-flight beats, accumulates the per-beat adder sums into a wide accumulator, and returns one tagged result per burst.

---
 rtl/moa_rr_sched_if.sv | 40 ++++
 rtl/moa_rr_sched.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/moa_rr_sched_if.sv
// ---------------------------------------------------------------------------
// moa_rr_sched_if
// Bundles every handshake and data signal of the round-robin adder scheduler.
//   req_valid/req_last/req_data/req_ready : per-requester beat channel
//   moa_x/moa_summ                         : shared multi-operand adder link
//   res_valid/res_ready/res_data/res_id/
//   res_beats/res_ovf                      : per-burst tagged result channel
// The "slave" modport is the scheduler's view; "master" is the environment
// (requesters, adder and result consumer) seen from the other side.
// ---------------------------------------------------------------------------
interface moa_rr_sched_if #(
   parameter int NREQ = 4,
   parameter int OPW  = 8,
   parameter int SUMW = 11,
   parameter int ACCW = 16,
   parameter int IDW  = 2
);
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_last;
   logic [NREQ*8*OPW-1:0] req_data;
   logic [NREQ-1:0]       req_ready;
   logic [8*OPW-1:0]      moa_x;
   logic [SUMW-1:0]       moa_summ;
   logic                  res_valid;
   logic                  res_ready;
   logic [ACCW-1:0]       res_data;
   logic [IDW-1:0]        res_id;
   logic [7:0]            res_beats;
   logic                  res_ovf;

   modport slave (
      input  req_valid, req_last, req_data, moa_summ, res_ready,
      output req_ready, moa_x, res_valid, res_data, res_id, res_beats, res_ovf
   );

   modport master (
      output req_valid, req_last, req_data, moa_summ, res_ready,
      input  req_ready, moa_x, res_valid, res_data, res_id, res_beats, res_ovf
   );
endinterface

// File: rtl/moa_rr_sched.sv
// ---------------------------------------------------------------------------
// moa_rr_sched
// Round-robin scheduler sharing one 8-operand, MOA_LAT-stage pipelined adder
// among NREQ requesters. One requester is granted for a whole burst; each
// accepted beat is driven into the adder, the returning per-beat sums are
// accumulated, and one tagged result is offered per burst.
// Ports:
//   clk    : clock
//   rst_n  : asynchronous active-low reset
//   bus    : moa_rr_sched_if.slave (request beats, adder link, result)
// ---------------------------------------------------------------------------
module moa_rr_sched #(
   parameter int NREQ    = 4,
   parameter int OPW     = 8,
   parameter int SUMW    = 11,
   parameter int MOA_LAT = 2,
   parameter int ACCW    = 16,
   parameter int IDW     = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   moa_rr_sched_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DRAIN = 2'd2,
      OUT   = 2'd3
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [IDW-1:0]     ptr;
   logic [IDW-1:0]     grant;
   logic [IDW-1:0]     pick;
   logic               pick_found;
   logic               accept;
   logic [ACCW-1:0]    acc;
   logic [ACCW:0]      acc_sum;
   logic               ovf;
   logic [7:0]         beats;
   logic [MOA_LAT-1:0] pipe_vld;
   int                 idx;

   // Round-robin pick: scan ptr, ptr+1, ... modulo NREQ. The loop runs from
   // the farthest offset down to offset 0 so the nearest valid index is the
   // last one written and therefore wins.
   always_comb begin
      pick       = ptr;
      pick_found = 1'b0;
      idx        = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % NREQ;
         if (bus.req_valid[idx]) begin
            pick       = idx[IDW-1:0];
            pick_found = 1'b1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next-state and handshake outputs. Only the granted requester sees
   // ready, and the adder is fed zeros whenever no beat is being accepted.
   // DRAIN waits until the in-flight valid pipe is empty, which also covers
   // the final accumulate still owed by the last beat.
   always_comb begin
      state_next    = state;
      bus.req_ready = '0;
      bus.moa_x     = '0;
      accept        = 1'b0;
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_next = BURST;
            end
         end
         BURST: begin
            bus.req_ready[grant] = 1'b1;
            accept = bus.req_valid[grant];
            if (accept) begin
               bus.moa_x = bus.req_data[int'(grant)*(8*OPW) +: 8*OPW];
               if (bus.req_last[grant]) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pipe_vld == '0) begin
               state_next = OUT;
            end
         end
         OUT: begin
            if (bus.res_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // One extra bit catches the carry out of the accumulator MSB.
   assign acc_sum = {1'b0, acc} + {{(ACCW + 1 - SUMW){1'b0}}, bus.moa_summ};

   // Datapath. The valid pipe mirrors the adder latency so its output lines
   // up with the cycle in which moa_summ belongs to an accepted beat. The
   // grant, accumulator, beat count and overflow are all re-armed at the
   // IDLE edge that starts a burst; the pipe is empty then, so no accumulate
   // can collide with the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr      <= '0;
         grant    <= '0;
         acc      <= '0;
         ovf      <= 1'b0;
         beats    <= '0;
         pipe_vld <= '0;
      end else begin
         pipe_vld <= {pipe_vld[MOA_LAT-2:0], accept};
         if (state == IDLE && pick_found) begin
            grant <= pick;
            acc   <= '0;
            ovf   <= 1'b0;
            beats <= '0;
         end else begin
            if (pipe_vld[MOA_LAT-1]) begin
               acc <= acc_sum[ACCW-1:0];
               if (acc_sum[ACCW]) begin
                  ovf <= 1'b1;
               end
            end
            if (accept && beats != 8'hFF) begin
               beats <= beats + 8'd1;
            end
         end
         if (state == OUT && bus.res_ready) begin
            ptr <= (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
         end
      end
   end

   // Result fields come straight from the burst registers; none of them can
   // change while in OUT, so they hold steady under back-pressure.
   assign bus.res_valid = (state == OUT);
   assign bus.res_data  = acc;
   assign bus.res_id    = grant;
   assign bus.res_beats = beats;
   assign bus.res_ovf   = ovf;

endmodule
